// File: rtl/div16_ctl.sv
// -----------------------------------------------------------------------------
// div16_ctl
//
// Request/response front end for a 16-bit serial unsigned divider that has a
// fixed latency of LAT clocks from its load strobe to its valid output. One
// operation is in flight at a time.
//
// A request (dividend, divisor, tag) is accepted over a valid/ready handshake.
// A non-zero divisor is forwarded to the divider with a one-cycle load strobe,
// and the divider's valid pulse must arrive exactly LAT cycles later. If it
// does not, the result is flagged as an error. A zero divisor is answered
// directly, without starting the divider. The result is held in an output
// register until the consumer takes it.
//
// After reset the block waits LAT+1 cycles before it accepts work. This lets
// any valid pulse from a job that was abandoned by the reset leave the
// divider before a new job can start.
//
// Parameters
//   LAT     divider latency, load-strobe cycle to valid-output cycle
//   TW      width of the user tag carried with each request
//
// Ports
//   clk     master clock, rising edge
//   rst     synchronous active-high reset
//   i_a     dividend                      i_b     divisor
//   i_tag   request tag                   i_vld   request valid
//   i_rdy   request ready (transfer on i_vld & i_rdy)
//   div_a   dividend to divider           div_b   divisor to divider
//   div_iv  divider load strobe (one-cycle pulse)
//   div_q   divider quotient              div_ov  divider output valid
//   o_q     quotient result               o_tag   tag of the result
//   o_dz    result was a divide by zero   o_err   divider valid missing
//   o_vld   result valid                  o_rdy   consumer ready
// -----------------------------------------------------------------------------
module div16_ctl #(
    parameter int unsigned LAT = 17,
    parameter int unsigned TW  = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [15:0]   i_a,
    input  logic [15:0]   i_b,
    input  logic [TW-1:0] i_tag,
    input  logic          i_vld,
    output logic          i_rdy,

    output logic [15:0]   div_a,
    output logic [15:0]   div_b,
    output logic          div_iv,
    input  logic [15:0]   div_q,
    input  logic          div_ov,

    output logic [15:0]   o_q,
    output logic [TW-1:0] o_tag,
    output logic          o_dz,
    output logic          o_err,
    output logic          o_vld,
    input  logic          o_rdy
);

    // The counter must reach LAT+1 during the post-reset flush.
    localparam int unsigned CW = $clog2(LAT + 2);

    localparam logic [CW-1:0] LAT_C = CW'(LAT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    // Result value reported for divide-by-zero and for a missing valid.
    localparam logic [15:0] Q_BAD = 16'hFFFF;

    typedef enum logic [2:0] {
        FLUSH = 3'd0,
        IDLE  = 3'd1,
        LOAD  = 3'd2,
        BUSY  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tag_r;

    // Transfer qualifiers, kept as named signals for readability.
    logic            req_xfer;
    logic            rsp_xfer;
    logic            div_zero;

    assign req_xfer = i_vld & i_rdy;
    assign rsp_xfer = o_vld & o_rdy;
    assign div_zero = (i_b == 16'd0);

    // Single control process. Every output is a flop that is set on the
    // transition into the state that owns it, so the handshake and strobe
    // outputs never glitch.
    // NOTE: all state here is assigned with <= so that every flop samples
    // the values from before this edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FLUSH;
            cnt    <= '0;
            i_rdy  <= 1'b0;
            div_iv <= 1'b0;
            o_vld  <= 1'b0;
            o_q    <= '0;
            o_tag  <= '0;
            o_dz   <= 1'b0;
            o_err  <= 1'b0;
            div_a  <= '0;
            div_b  <= '0;
            tag_r  <= '0;
        end else begin
            // The load strobe is high for one cycle only. It is raised
            // again below only on the accept that enters LOAD.
            div_iv <= 1'b0;

            unique case (state)
                // Wait out any valid pulse of a job abandoned by reset.
                // div_ov is ignored here. The counter goes from LAT to
                // LAT+1 on the same edge that moves the FSM to IDLE, so
                // i_rdy stays low for exactly LAT+1 cycles.
                FLUSH: begin
                    cnt <= cnt + ONE_C;
                    if (cnt == LAT_C) begin
                        state <= IDLE;
                        i_rdy <= 1'b1;
                    end
                end

                IDLE: begin
                    if (req_xfer) begin
                        div_a <= i_a;
                        div_b <= i_b;
                        tag_r <= i_tag;
                        i_rdy <= 1'b0;
                        cnt   <= '0;
                        if (div_zero) begin
                            // Answer at once; the divider is never started.
                            o_q   <= Q_BAD;
                            o_dz  <= 1'b1;
                            o_err <= 1'b0;
                            o_tag <= i_tag;
                            o_vld <= 1'b1;
                            state <= HOLD;
                        end else begin
                            div_iv <= 1'b1;
                            state  <= LOAD;
                        end
                    end
                end

                // div_iv is high during this cycle, and div_a/div_b are
                // stable from the registers. The counter was cleared on
                // accept and counts this cycle, so it reads 1 in the first
                // BUSY cycle and LAT in the cycle the divider's valid is due.
                LOAD: begin
                    cnt   <= cnt + ONE_C;
                    state <= BUSY;
                end

                // Only a valid pulse at exactly the expected cycle is taken.
                // A pulse on any other cycle is a stray and is dropped.
                BUSY: begin
                    cnt <= cnt + ONE_C;
                    if (cnt == LAT_C) begin
                        o_tag <= tag_r;
                        o_dz  <= 1'b0;
                        o_vld <= 1'b1;
                        state <= HOLD;
                        if (div_ov) begin
                            o_q   <= div_q;
                            o_err <= 1'b0;
                        end else begin
                            o_q   <= Q_BAD;
                            o_err <= 1'b1;
                        end
                    end
                end

                // The result is frozen until it is taken. i_rdy stays low,
                // so a new request is never accepted in the drain cycle.
                HOLD: begin
                    if (rsp_xfer) begin
                        o_vld <= 1'b0;
                        i_rdy <= 1'b1;
                        state <= IDLE;
                    end
                end

                // Illegal encoding: restart through a full flush, because a
                // divider job may still be in flight.
                default: begin
                    state <= FLUSH;
                    cnt   <= '0;
                    i_rdy <= 1'b0;
                    o_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div16_ctl.sv
// -----------------------------------------------------------------------------
// tb_div16_ctl
//
// Directed bench for div16_ctl. A behavioural divider sits on the divider
// port. It is not reset by rst, so a job abandoned at reset still produces its
// valid pulse. It has knobs to suppress the on-time valid and to inject a stray
// valid at count 5. Expected values are hand-computed constants.
// Outputs are sampled on the falling edge. Inputs are driven on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_div16_ctl;

    localparam int unsigned LAT = 17;
    localparam int unsigned TW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   i_a, i_b;
    logic [TW-1:0] i_tag;
    logic          i_vld;
    logic          i_rdy;
    logic [15:0]   div_a, div_b;
    logic          div_iv;
    logic [15:0]   div_q;
    logic          div_ov;
    logic [15:0]   o_q;
    logic [TW-1:0] o_tag;
    logic          o_dz, o_err, o_vld;
    logic          o_rdy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div16_ctl #(.LAT(LAT), .TW(TW)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_tag  (i_tag),
        .i_vld  (i_vld),
        .i_rdy  (i_rdy),
        .div_a  (div_a),
        .div_b  (div_b),
        .div_iv (div_iv),
        .div_q  (div_q),
        .div_ov (div_ov),
        .o_q    (o_q),
        .o_tag  (o_tag),
        .o_dz   (o_dz),
        .o_err  (o_err),
        .o_vld  (o_vld),
        .o_rdy  (o_rdy)
    );

    // ---------------- behavioural divider ----------------
    logic        m_busy = 1'b0;
    logic [7:0]  m_cnt  = '0;
    logic [15:0] m_q    = '0;
    logic        suppress = 1'b0;
    logic        stray    = 1'b0;
    int          iv_count = 0;

    always @(posedge clk) begin
        if (div_iv) begin
            m_busy <= 1'b1;
            m_cnt  <= 8'd1;
            m_q    <= (div_b != 16'd0) ? div_a / div_b : 16'd0;
        end else if (m_busy) begin
            if (m_cnt == 8'(LAT)) m_busy <= 1'b0;
            else                  m_cnt  <= m_cnt + 8'd1;
        end
        if (div_iv) iv_count <= iv_count + 1;
    end

    assign div_q  = m_q;
    assign div_ov = m_busy && ((m_cnt == 8'(LAT) && !suppress) ||
                               (stray && m_cnt == 8'd5));

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [15:0] a, input logic [15:0] b,
                             input logic [TW-1:0] t);
        i_a   = a;
        i_b   = b;
        i_tag = t;
        i_vld = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst   = 1'b1;
        i_a   = '0;
        i_b   = '0;
        i_tag = '0;
        i_vld = 1'b0;
        o_rdy = 1'b1;
        tick(3);

        // Reset state.
        check("rst_i_rdy",  32'(i_rdy),  32'd0);
        check("rst_div_iv", 32'(div_iv), 32'd0);
        check("rst_o_vld",  32'(o_vld),  32'd0);
        check("rst_o_q",    32'(o_q),    32'd0);
        check("rst_o_tag",  32'(o_tag),  32'd0);
        check("rst_o_dz",   32'(o_dz),   32'd0);
        check("rst_o_err",  32'(o_err),  32'd0);
        check("rst_div_a",  32'(div_a),  32'd0);
        check("rst_div_b",  32'(div_b),  32'd0);

        // Release reset with a request already pending: held off for LAT+1.
        rst = 1'b0;
        drive_req(16'd1000, 16'd7, 4'd3);
        for (int k = 0; k < 18; k++) begin
            check("flush_i_rdy", 32'(i_rdy), 32'd0);
            tick(1);
        end
        check("idle_i_rdy", 32'(i_rdy), 32'd1);      // cycle T, accepted

        // 1000 / 7 = 142.
        tick(1);                                      // T+1 LOAD
        i_vld = 1'b0;
        check("t1_div_iv", 32'(div_iv), 32'd1);
        check("t1_div_a",  32'(div_a),  32'd1000);
        check("t1_div_b",  32'(div_b),  32'd7);
        tick(1);                                      // T+2
        check("t1_iv_pulse", 32'(div_iv), 32'd0);
        tick(16);                                     // T+18
        check("t1_early_vld", 32'(o_vld), 32'd0);
        tick(1);                                      // T+19
        check("t1_o_vld", 32'(o_vld), 32'd1);
        check("t1_o_q",   32'(o_q),   32'd142);
        check("t1_o_tag", 32'(o_tag), 32'd3);
        check("t1_o_dz",  32'(o_dz),  32'd0);
        check("t1_o_err", 32'(o_err), 32'd0);
        check("t1_iv_cnt", 32'(iv_count), 32'd1);
        tick(1);                                      // T+20 IDLE
        check("t1_drain_vld", 32'(o_vld), 32'd0);
        check("t1_drain_rdy", 32'(i_rdy), 32'd1);

        // 5 / 0: answered next cycle, divider untouched.
        drive_req(16'd5, 16'd0, 4'd9);
        tick(1);                                      // T+1
        i_vld = 1'b0;
        check("dz_o_vld",  32'(o_vld),  32'd1);
        check("dz_o_q",    32'(o_q),    32'hFFFF);
        check("dz_o_dz",   32'(o_dz),   32'd1);
        check("dz_o_err",  32'(o_err),  32'd0);
        check("dz_o_tag",  32'(o_tag),  32'd9);
        check("dz_div_iv", 32'(div_iv), 32'd0);
        tick(1);                                      // T+2 IDLE
        check("dz_drain_vld", 32'(o_vld), 32'd0);
        check("dz_i_rdy",     32'(i_rdy), 32'd1);
        check("dz_iv_cnt",    32'(iv_count), 32'd1);

        // 65535 / 1 with back-pressure for 10 cycles.
        o_rdy = 1'b0;
        drive_req(16'd65535, 16'd1, 4'd5);
        tick(1);                                      // T+1
        check("bp_div_iv", 32'(div_iv), 32'd1);
        drive_req(16'd7, 16'd7, 4'd1);                // must not be accepted
        tick(17);                                     // T+18
        check("bp_early_vld", 32'(o_vld), 32'd0);
        tick(1);                                      // T+19
        check("bp_o_vld", 32'(o_vld), 32'd1);
        check("bp_o_q",   32'(o_q),   32'hFFFF);
        check("bp_o_dz",  32'(o_dz),  32'd0);
        check("bp_o_err", 32'(o_err), 32'd0);
        check("bp_o_tag", 32'(o_tag), 32'd5);
        for (int k = 0; k < 10; k++) begin            // T+20 .. T+29
            tick(1);
            check("bp_hold_vld", 32'(o_vld), 32'd1);
            check("bp_hold_q",   32'(o_q),   32'hFFFF);
            check("bp_hold_rdy", 32'(i_rdy), 32'd0);
        end
        check("bp_div_a_kept", 32'(div_a), 32'd65535);
        i_vld = 1'b0;
        o_rdy = 1'b1;
        tick(1);                                      // T+30 IDLE
        check("bp_drain_vld", 32'(o_vld), 32'd0);
        check("bp_drain_rdy", 32'(i_rdy), 32'd1);

        // Missing valid plus a stray valid at count 5.
        suppress = 1'b1;
        stray    = 1'b1;
        drive_req(16'd10, 16'd2, 4'd6);
        tick(1);                                      // T+1
        i_vld = 1'b0;
        tick(6);                                      // T+7, stray was T+6
        check("err_stray_vld", 32'(o_vld), 32'd0);
        tick(11);                                     // T+18
        check("err_early_vld", 32'(o_vld), 32'd0);
        tick(1);                                      // T+19
        check("err_o_vld", 32'(o_vld), 32'd1);
        check("err_o_err", 32'(o_err), 32'd1);
        check("err_o_q",   32'(o_q),   32'hFFFF);
        check("err_o_dz",  32'(o_dz),  32'd0);
        check("err_o_tag", 32'(o_tag), 32'd6);
        tick(1);                                      // T+20 IDLE
        suppress = 1'b0;
        stray    = 1'b0;
        check("err_drain_rdy", 32'(i_rdy), 32'd1);

        // Reset in BUSY at counter 8, then a new job straight after release.
        drive_req(16'd200, 16'd4, 4'd1);
        tick(1);                                      // T+1
        i_vld = 1'b0;
        tick(8);                                      // T+9, counter 8
        rst = 1'b1;
        tick(1);                                      // T+10
        check("mid_rst_o_vld", 32'(o_vld), 32'd0);
        check("mid_rst_i_rdy", 32'(i_rdy), 32'd0);
        check("mid_rst_o_q",   32'(o_q),   32'd0);
        check("mid_rst_div_a", 32'(div_a), 32'd0);
        tick(1);                                      // T+11
        rst = 1'b0;
        drive_req(16'd100, 16'd10, 4'd2);
        for (int k = 0; k < 18; k++) begin            // old div_ov lands here
            check("mr_flush_rdy", 32'(i_rdy), 32'd0);
            check("mr_flush_vld", 32'(o_vld), 32'd0);
            tick(1);
        end
        check("mr_idle_rdy", 32'(i_rdy), 32'd1);
        tick(1);                                      // T'+1
        i_vld = 1'b0;
        check("mr_div_iv", 32'(div_iv), 32'd1);
        check("mr_div_a",  32'(div_a),  32'd100);
        tick(17);                                     // T'+18
        check("mr_early_vld", 32'(o_vld), 32'd0);
        tick(1);                                      // T'+19
        check("mr_o_vld", 32'(o_vld), 32'd1);
        check("mr_o_q",   32'(o_q),   32'd10);
        check("mr_o_err", 32'(o_err), 32'd0);
        check("mr_o_dz",  32'(o_dz),  32'd0);
        check("mr_o_tag", 32'(o_tag), 32'd2);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
